pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Registered program-counter unit for the LEGv8 core. Holds the architectural PC and computes the next PC each cycle.
- Target sources: sequential (PC+4), conditional branch (CBZ/CBNZ), unconditional branch (B), branch-and-link (BL), register branch (BR) and return (RET).
- Adds stall and a parametrised return-address stack (RAS).
- Sits between the fetch stage and the decode/ALU control; drives the instruction-memory address.

Parameters:
- AW, 64, PC/immediate/target width in bits.
- RESET_PC, 64'h0, PC value loaded on reset (truncated to AW).
- IMM_SHIFT, 2, left shift applied to SignExtImm before adding to CurrentPC.
- RAS_DEPTH, 4, return-address stack entries; power of two, >=2.

Ports:
- CLK  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Stall  input  1  hold PC and RAS unchanged this cycle
- Branch  input  1  conditional branch instruction
- BranchNonZero  input  1  with Branch: 1=CBNZ (take on !ALUZero), 0=CBZ (take on ALUZero)
- ALUZero  input  1  ALU zero flag
- Uncondbranch  input  1  B instruction
- Link  input  1  BL instruction: PC-relative jump plus push of return address
- RegBranch  input  1  BR instruction: jump to RegTarget
- Ret  input  1  RET instruction: pop RAS
- SignExtImm  input  AW  sign-extended branch offset in words
- RegTarget  input  AW  register-file read value (Rn / X30)
- CurrentPC  output  AW  registered PC
- NextPC  output  AW  combinational next-PC value (loaded at next edge unless Stall)
- BranchTaken  output  1  combinational; 1 when NextPC != CurrentPC+4 due to redirect
- RasCount  output  $clog2(RAS_DEPTH)+1  valid RAS entries
- RasUnderflow  output  1  registered sticky flag; set by RET on empty RAS; cleared by Reset only
- PerfTaken  output  32  taken-redirect counter (see Optional Feature)
- PerfRetired  output  32  non-stalled cycle counter (see Optional Feature)

Behaviour:
- Reset (sync, highest priority): CurrentPC=RESET_PC, RasCount=0, RasUnderflow=0, RAS pointer=0, perf counters=0. RAS entry contents don't-care.
- Reset mid-operation overrides Stall and all redirects in the same cycle.
- Seq = CurrentPC+4. Rel = CurrentPC + (SignExtImm<<IMM_SHIFT). All arithmetic modulo 2^AW; wrap-around is silent.
- NextPC selection, priority high→low:
  - Ret: NextPC=RAS top if RasCount>0, else RegTarget.
  - RegBranch: NextPC=RegTarget.
  - Link or Uncondbranch: NextPC=Rel.
  - Branch with condition met (ALUZero ^ BranchNonZero): NextPC=Rel.
  - otherwise: NextPC=Seq.
- BranchTaken=1 for any selected non-Seq source, even if the target numerically equals Seq.
- Edge update when !Reset && !Stall: CurrentPC<=NextPC. Latency: one cycle from control inputs to CurrentPC.
- Stall=1: CurrentPC, RAS, RasCount, RasUnderflow and PerfRetired all hold. NextPC/BranchTaken still reflect inputs.
- RAS push (Link wins the priority, !Stall): write Seq at top, pointer++ modulo RAS_DEPTH, RasCount=min(RasCount+1, RAS_DEPTH).
- RAS full on push: the oldest entry is overwritten (circular buffer); RasCount stays RAS_DEPTH.
- RAS pop (Ret, !Stall): if RasCount>0, pointer-- modulo RAS_DEPTH and RasCount-1. If RasCount==0, no pointer change and RasUnderflow<=1.
- Simultaneous Ret+Link: Ret wins; no push.
- Simultaneous RegBranch+Link: RegBranch wins; no push.
- Multiple lower-priority inputs active: only the highest-priority one has effect.
- No # delays; fully synthesizable.

Optional Feature:
- Macro PC_SEQUENCER_PERF_EN.
- Defined:
  - PerfRetired increments on every non-Reset, non-Stall cycle.
  - PerfTaken increments on such cycles when BranchTaken=1.
  - Both are 32-bit, wrap at 2^32, zeroed on Reset.
- Undefined: PerfTaken and PerfRetired tied to 0; no counter flops.

Test Plan:
- Reset with RESET_PC=64'h100, then 3 idle cycles → CurrentPC 100, 104, 108, 10C; BranchTaken=0; RasCount=0.
- At PC=0x200: Branch=1, BranchNonZero=0, ALUZero=1, Imm=-4 → CurrentPC=0x1F0. Repeat with ALUZero=0 → 0x204. CBNZ with ALUZero=0, Imm=3 → 0x20C.
- BL at 0x400 with Imm=0x10 → CurrentPC=0x440, RasCount=1. Ret at next cycle → CurrentPC=0x404, RasCount=0, RasUnderflow=0.
- RAS_DEPTH=4: five BLs from PCs 0x0, 0x100, 0x200, 0x300, 0x400 (return addresses 0x4–0x404), then five RETs with RegTarget=0xDEAD0 → pops 0x404, 0x304, 0x204, 0x104, then 0xDEAD0. RasCount goes 4→0; RasUnderflow=1 after the fifth RET.
- Stall=1 for 2 cycles with Link=1 at PC=0x80 → CurrentPC stays 0x80, RasCount unchanged, NextPC shows target. Stall drops → one push, jump taken. Reset asserted with Stall=1 → CurrentPC=RESET_PC next edge.
- With PC_SEQUENCER_PERF_EN: 10 cycles including 3 taken branches and 2 stalls → PerfRetired=8, PerfTaken=3. Without the macro → both 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter for the LEGv8 core.
//
// Holds the architectural PC and computes the next PC each cycle from the
// sequential, PC-relative, register and return-address-stack sources.
// A circular return-address stack (RAS) is pushed by BL and popped by RET.
//
// Optional build macro: PC_SEQUENCER_PERF_EN
//   defined   -> PerfTaken / PerfRetired are live 32-bit counters
//   undefined -> both outputs are tied to zero and no counter flops exist
module pc_sequencer #(
    parameter int          AW        = 64,
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          IMM_SHIFT = 2,
    parameter int          RAS_DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       Stall,
    input  logic                       Branch,
    input  logic                       BranchNonZero,
    input  logic                       ALUZero,
    input  logic                       Uncondbranch,
    input  logic                       Link,
    input  logic                       RegBranch,
    input  logic                       Ret,
    input  logic [AW-1:0]              SignExtImm,
    input  logic [AW-1:0]              RegTarget,
    output logic [AW-1:0]              CurrentPC,
    output logic [AW-1:0]              NextPC,
    output logic                       BranchTaken,
    output logic [$clog2(RAS_DEPTH):0] RasCount,
    output logic                       RasUnderflow,
    output logic [31:0]                PerfTaken,
    output logic [31:0]                PerfRetired
);

    // Pointer indexes the next free RAS slot; count needs one extra bit
    // so that a full stack (RAS_DEPTH entries) is representable.
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [AW-1:0] RESET_PC_AW = RESET_PC[AW-1:0];
    localparam logic [CW-1:0] RAS_FULL    = CW'(RAS_DEPTH);
    localparam logic [CW-1:0] RAS_EMPTY   = '0;

    // Which value feeds NextPC this cycle.
    typedef enum logic [1:0] {
        SRC_SEQ = 2'd0,
        SRC_RAS = 2'd1,
        SRC_REG = 2'd2,
        SRC_REL = 2'd3
    } src_e;

    // What the winning instruction asks of the return-address stack.
    typedef enum logic [1:0] {
        RAS_IDLE = 2'd0,
        RAS_PUSH = 2'd1,
        RAS_POP  = 2'd2
    } ras_op_e;

    logic [AW-1:0] pc_q, pc_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          unf_q, unf_d;

    logic [AW-1:0] ras_mem [RAS_DEPTH];

    logic [AW-1:0] seq_pc;
    logic [AW-1:0] rel_pc;
    logic [AW-1:0] ras_top;
    logic [AW-1:0] next_pc;
    logic          cond_met;
    logic          push_en;
    src_e          src;
    ras_op_e       ras_op;

    // Candidate targets; all arithmetic wraps silently at 2^AW.
    always_comb begin
        seq_pc   = pc_q + AW'(4);
        rel_pc   = pc_q + (SignExtImm << IMM_SHIFT);
        ras_top  = ras_mem[ptr_q - PW'(1)];
        cond_met = Branch & (ALUZero ^ BranchNonZero);
    end

    // Priority decode: Ret > RegBranch > Link/Uncondbranch > taken Branch > Seq.
    always_comb begin
        src    = SRC_SEQ;
        ras_op = RAS_IDLE;
        if (Ret) begin
            // An empty stack falls back to the register value (X30).
            src    = (cnt_q != RAS_EMPTY) ? SRC_RAS : SRC_REG;
            ras_op = RAS_POP;
        end else if (RegBranch) begin
            src = SRC_REG;
        end else if (Link) begin
            src    = SRC_REL;
            ras_op = RAS_PUSH;
        end else if (Uncondbranch) begin
            src = SRC_REL;
        end else if (cond_met) begin
            src = SRC_REL;
        end
    end

    // Next-PC mux; BranchTaken flags any redirect even if it equals Seq.
    always_comb begin
        next_pc = seq_pc;
        case (src)
            SRC_RAS: next_pc = ras_top;
            SRC_REG: next_pc = RegTarget;
            SRC_REL: next_pc = rel_pc;
            default: next_pc = seq_pc;
        endcase
        NextPC      = next_pc;
        BranchTaken = (src != SRC_SEQ);
    end

    // Next-state for PC and stack bookkeeping; Stall freezes everything.
    always_comb begin
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (!Stall) begin
            pc_d = next_pc;
            case (ras_op)
                RAS_PUSH: begin
                    // When full, the pointer wraps onto the oldest entry
                    // and the count saturates.
                    push_en = 1'b1;
                    ptr_d   = ptr_q + PW'(1);
                    if (cnt_q != RAS_FULL) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RAS_POP: begin
                    if (cnt_q != RAS_EMPTY) begin
                        ptr_d = ptr_q - PW'(1);
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        unf_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register; synchronous reset overrides Stall and all redirects.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q  <= RESET_PC_AW;
            ptr_q <= '0;
            cnt_q <= '0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            unf_q <= unf_d;
        end
    end

    // RAS storage: one write-enabled register per slot, no reset needed
    // since entries above the count are never read as valid.
    generate
        for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
            // Capture the return address into the slot under the pointer.
            always_ff @(posedge CLK) begin
                if (!Reset && push_en && (ptr_q == PW'(gi))) begin
                    ras_mem[gi] <= seq_pc;
                end
            end
        end
    endgenerate

    assign CurrentPC    = pc_q;
    assign RasCount     = cnt_q;
    assign RasUnderflow = unf_q;

`ifdef PC_SEQUENCER_PERF_EN
    logic [31:0] perf_taken_q, perf_taken_d;
    logic [31:0] perf_retired_q, perf_retired_d;

    // Count every non-stalled cycle, and the redirects among them.
    always_comb begin
        perf_taken_d   = perf_taken_q;
        perf_retired_d = perf_retired_q;
        if (!Stall) begin
            perf_retired_d = perf_retired_q + 32'd1;
            if (BranchTaken) begin
                perf_taken_d = perf_taken_q + 32'd1;
            end
        end
    end

    // Counter registers, cleared by reset, wrapping at 2^32.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            perf_taken_q   <= '0;
            perf_retired_q <= '0;
        end else begin
            perf_taken_q   <= perf_taken_d;
            perf_retired_q <= perf_retired_d;
        end
    end

    assign PerfTaken   = perf_taken_q;
    assign PerfRetired = perf_retired_q;
`else
    assign PerfTaken   = 32'd0;
    assign PerfRetired = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed vector table, hand-written stall /
// reset / perf sequences, and randomized stimulus against a queue-based
// reference model of the PC and return-address stack.
module tb_pc_sequencer;

    localparam int          AW     = 64;
    localparam int          DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h100;
`ifdef PC_SEQUENCER_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    // Control-bit masks: {rst, stall, br, bnz, z, ub, lk, rb, rt}
    localparam logic [8:0] C_RST = 9'b100000000;
    localparam logic [8:0] C_STL = 9'b010000000;
    localparam logic [8:0] C_BR  = 9'b001000000;
    localparam logic [8:0] C_BNZ = 9'b000100000;
    localparam logic [8:0] C_Z   = 9'b000010000;
    localparam logic [8:0] C_UB  = 9'b000001000;
    localparam logic [8:0] C_LK  = 9'b000000100;
    localparam logic [8:0] C_RB  = 9'b000000010;
    localparam logic [8:0] C_RT  = 9'b000000001;
    localparam logic [8:0] C_NOP = 9'b000000000;
    localparam logic [63:0] M4   = 64'hFFFF_FFFF_FFFF_FFFC;

    logic          CLK = 1'b0;
    logic          Reset, Stall, Branch, BranchNonZero, ALUZero;
    logic          Uncondbranch, Link, RegBranch, Ret;
    logic [AW-1:0] SignExtImm, RegTarget;
    logic [AW-1:0] CurrentPC, NextPC;
    logic          BranchTaken;
    logic [2:0]    RasCount;
    logic          RasUnderflow;
    logic [31:0]   PerfTaken, PerfRetired;

    pc_sequencer #(
        .AW(AW), .RESET_PC(RST_PC), .IMM_SHIFT(2), .RAS_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .Reset(Reset), .Stall(Stall), .Branch(Branch),
        .BranchNonZero(BranchNonZero), .ALUZero(ALUZero),
        .Uncondbranch(Uncondbranch), .Link(Link), .RegBranch(RegBranch),
        .Ret(Ret), .SignExtImm(SignExtImm), .RegTarget(RegTarget),
        .CurrentPC(CurrentPC), .NextPC(NextPC), .BranchTaken(BranchTaken),
        .RasCount(RasCount), .RasUnderflow(RasUnderflow),
        .PerfTaken(PerfTaken), .PerfRetired(PerfRetired)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [8:0]  ctl;
        logic [63:0] imm;
        logic [63:0] rtgt;
    } in_t;

    typedef struct {
        in_t         in;
        logic [63:0] exp_next;
        logic        exp_taken;
        logic [63:0] exp_pc;
        int          exp_cnt;
        bit          exp_unf;
        bit          chk_comb;
    } vec_t;

    // Reference model state: architectural PC and a bounded return stack.
    logic [63:0] m_pc;
    logic [63:0] m_ras[$];
    bit          m_unf;
    logic [31:0] m_ptaken, m_pretired;

    logic [63:0] cap_next;
    logic        cap_taken;

    function automatic in_t mk(input logic [8:0] c, input logic [63:0] imm,
                               input logic [63:0] rtgt);
        in_t r;
        r.ctl  = c;
        r.imm  = imm;
        r.rtgt = rtgt;
        return r;
    endfunction

    function automatic vec_t V(input logic [8:0] c, input logic [63:0] imm,
                               input logic [63:0] rtgt, input logic [63:0] nx,
                               input logic tk, input logic [63:0] pc,
                               input int cnt, input bit unf, input bit cc);
        vec_t r;
        r.in        = mk(c, imm, rtgt);
        r.exp_next  = nx;
        r.exp_taken = tk;
        r.exp_pc    = pc;
        r.exp_cnt   = cnt;
        r.exp_unf   = unf;
        r.chk_comb  = cc;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apply(input in_t v);
        {Reset, Stall, Branch, BranchNonZero, ALUZero,
         Uncondbranch, Link, RegBranch, Ret} = v.ctl;
        SignExtImm = v.imm;
        RegTarget  = v.rtgt;
    endtask

    // Next PC from the instruction-set rules, using the model's state.
    function automatic void model_next(input in_t v, output logic [63:0] nx,
                                       output bit tk);
        logic [63:0] rel;
        rel = m_pc + (v.imm * 64'd4);
        tk  = 1'b1;
        if (v.ctl[0]) begin
            nx = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : v.rtgt;
        end else if (v.ctl[1]) begin
            nx = v.rtgt;
        end else if (v.ctl[2] || v.ctl[3]) begin
            nx = rel;
        end else if (v.ctl[6] && (v.ctl[4] != v.ctl[5])) begin
            nx = rel;
        end else begin
            nx = m_pc + 64'd4;
            tk = 1'b0;
        end
    endfunction

    task automatic model_update(input in_t v, input logic [63:0] nx, input bit tk);
        if (v.ctl[8]) begin
            m_pc = RST_PC;
            m_ras.delete();
            m_unf      = 1'b0;
            m_ptaken   = '0;
            m_pretired = '0;
        end else if (!v.ctl[7]) begin
            if (v.ctl[0]) begin
                if (m_ras.size() > 0) void'(m_ras.pop_back());
                else m_unf = 1'b1;
            end else if (!v.ctl[1] && v.ctl[2]) begin
                m_ras.push_back(m_pc + 64'd4);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            m_pc       = nx;
            m_pretired = m_pretired + 32'd1;
            if (tk) m_ptaken = m_ptaken + 32'd1;
        end
    endtask

    // One clock: drive, sample combinational outputs at the falling edge,
    // let the rising edge commit, then sample registered outputs.
    task automatic run_cycle(input in_t v, input bit cmp_model, input string tag);
        logic [63:0] enx;
        bit          etk;
        apply(v);
        @(negedge CLK);
        cap_next  = NextPC;
        cap_taken = BranchTaken;
        model_next(v, enx, etk);
        if (cmp_model && !v.ctl[8]) begin
            check({tag, "_next"},  NextPC, enx);
            check({tag, "_taken"}, {63'd0, BranchTaken}, {63'd0, etk});
        end
        model_update(v, enx, etk);
        @(posedge CLK);
        #1;
        if (cmp_model) begin
            check({tag, "_pc"},  CurrentPC, m_pc);
            check({tag, "_cnt"}, {61'd0, RasCount}, 64'(m_ras.size()));
            check({tag, "_unf"}, {63'd0, RasUnderflow}, {63'd0, m_unf});
            check({tag, "_ptaken"},  {32'd0, PerfTaken},
                  PERF_EN ? {32'd0, m_ptaken} : 64'd0);
            check({tag, "_pretired"}, {32'd0, PerfRetired},
                  PERF_EN ? {32'd0, m_pretired} : 64'd0);
        end
        $display("%s ctl=%09b imm=%h rtgt=%h next=%h tk=%0b pc=%h cnt=%0d unf=%0b",
                 tag, v.ctl, v.imm, v.rtgt, cap_next, cap_taken, CurrentPC,
                 RasCount, RasUnderflow);
    endtask

    task automatic expect_regs(input string tag, input logic [63:0] pc,
                               input int cnt, input bit unf);
        check({tag, "_pc"},  CurrentPC, pc);
        check({tag, "_cnt"}, {61'd0, RasCount}, 64'(cnt));
        check({tag, "_unf"}, {63'd0, RasUnderflow}, {63'd0, unf});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        in_t  r;
        m_pc = '0; m_unf = 1'b0; m_ptaken = '0; m_pretired = '0;

        // ---------------- directed vector table ----------------
        tbl.push_back(V(C_RST, 0, 0, 0, 0, 64'h100, 0, 0, 0));
        tbl.push_back(V(C_NOP, 0, 0, 64'h104, 0, 64'h104, 0, 0, 1));
        tbl.push_back(V(C_NOP, 0, 0, 64'h108, 0, 64'h108, 0, 0, 1));
        tbl.push_back(V(C_NOP, 0, 0, 64'h10C, 0, 64'h10C, 0, 0, 1));
        tbl.push_back(V(C_RB, 0, 64'h200, 64'h200, 1, 64'h200, 0, 0, 1));
        tbl.push_back(V(C_BR | C_Z, M4, 0, 64'h1F0, 1, 64'h1F0, 0, 0, 1));
        tbl.push_back(V(C_RB, 0, 64'h200, 64'h200, 1, 64'h200, 0, 0, 1));
        tbl.push_back(V(C_BR, M4, 0, 64'h204, 0, 64'h204, 0, 0, 1));
        tbl.push_back(V(C_RB, 0, 64'h200, 64'h200, 1, 64'h200, 0, 0, 1));
        tbl.push_back(V(C_BR | C_BNZ, 3, 0, 64'h20C, 1, 64'h20C, 0, 0, 1));
        tbl.push_back(V(C_RB, 0, 64'h400, 64'h400, 1, 64'h400, 0, 0, 1));
        tbl.push_back(V(C_LK, 64'h10, 0, 64'h440, 1, 64'h440, 1, 0, 1));
        tbl.push_back(V(C_RT, 0, 64'hBAD, 64'h404, 1, 64'h404, 0, 0, 1));
        tbl.push_back(V(C_RB, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(V(C_LK, 64'h40, 0, 64'h100, 1, 64'h100, 1, 0, 1));
        tbl.push_back(V(C_LK, 64'h40, 0, 64'h200, 1, 64'h200, 2, 0, 1));
        tbl.push_back(V(C_LK, 64'h40, 0, 64'h300, 1, 64'h300, 3, 0, 1));
        tbl.push_back(V(C_LK, 64'h40, 0, 64'h400, 1, 64'h400, 4, 0, 1));
        tbl.push_back(V(C_LK, 64'h40, 0, 64'h500, 1, 64'h500, 4, 0, 1));
        tbl.push_back(V(C_RT, 0, 64'hDEAD0, 64'h404, 1, 64'h404, 3, 0, 1));
        tbl.push_back(V(C_RT, 0, 64'hDEAD0, 64'h304, 1, 64'h304, 2, 0, 1));
        tbl.push_back(V(C_RT, 0, 64'hDEAD0, 64'h204, 1, 64'h204, 1, 0, 1));
        tbl.push_back(V(C_RT, 0, 64'hDEAD0, 64'h104, 1, 64'h104, 0, 0, 1));
        tbl.push_back(V(C_RT, 0, 64'hDEAD0, 64'hDEAD0, 1, 64'hDEAD0, 0, 1, 1));
        tbl.push_back(V(C_RT | C_LK, 8, 64'h1000, 64'h1000, 1, 64'h1000, 0, 1, 1));
        tbl.push_back(V(C_RB | C_LK, 5, 64'h2000, 64'h2000, 1, 64'h2000, 0, 1, 1));
        tbl.push_back(V(C_LK | C_UB | C_BR | C_Z, 1, 64'h9999, 64'h2004, 1, 64'h2004, 1, 1, 1));
        tbl.push_back(V(C_UB | C_BR | C_Z, 2, 64'h9999, 64'h200C, 1, 64'h200C, 1, 1, 1));
        tbl.push_back(V(C_RT, 0, 64'h3000, 64'h2004, 1, 64'h2004, 0, 1, 1));
        tbl.push_back(V(C_UB, 1, 0, 64'h2008, 1, 64'h2008, 0, 1, 1));
        tbl.push_back(V(C_BR | C_BNZ | C_Z, 7, 0, 64'h200C, 0, 64'h200C, 0, 1, 1));
        tbl.push_back(V(C_RB, 0, M4, M4, 1, M4, 0, 1, 1));
        tbl.push_back(V(C_NOP, 0, 0, 0, 0, 0, 0, 1, 1));

        foreach (tbl[i]) begin
            run_cycle(tbl[i].in, 1'b0, $sformatf("tbl%0d", i));
            if (tbl[i].chk_comb) begin
                check($sformatf("tbl%0d_next", i), cap_next, tbl[i].exp_next);
                check($sformatf("tbl%0d_taken", i), {63'd0, cap_taken},
                      {63'd0, tbl[i].exp_taken});
            end
            expect_regs($sformatf("tbl%0d", i), tbl[i].exp_pc,
                        tbl[i].exp_cnt, tbl[i].exp_unf);
        end

        // ---------------- stall / reset sequence ----------------
        run_cycle(mk(C_RST, 0, 0), 1'b0, "stl_rst");
        expect_regs("stl_rst", 64'h100, 0, 0);
        run_cycle(mk(C_RB, 0, 64'h80), 1'b0, "stl_go80");
        expect_regs("stl_go80", 64'h80, 0, 0);
        for (int k = 0; k < 2; k++) begin
            run_cycle(mk(C_STL | C_LK, 64'h10, 0), 1'b0, $sformatf("stl_hold%0d", k));
            check($sformatf("stl_hold%0d_next", k), cap_next, 64'hC0);
            check($sformatf("stl_hold%0d_taken", k), {63'd0, cap_taken}, 64'd1);
            expect_regs($sformatf("stl_hold%0d", k), 64'h80, 0, 0);
        end
        run_cycle(mk(C_LK, 64'h10, 0), 1'b0, "stl_release");
        expect_regs("stl_release", 64'hC0, 1, 0);
        run_cycle(mk(C_STL | C_RT, 0, 64'h55), 1'b0, "stl_ret_hold");
        check("stl_ret_hold_next", cap_next, 64'h84);
        expect_regs("stl_ret_hold", 64'hC0, 1, 0);
        run_cycle(mk(C_RT, 0, 64'h55), 1'b0, "stl_ret");
        expect_regs("stl_ret", 64'h84, 0, 0);
        run_cycle(mk(C_STL | C_RT, 0, 64'h77), 1'b0, "stl_unf_hold");
        check("stl_unf_hold_next", cap_next, 64'h77);
        expect_regs("stl_unf_hold", 64'h84, 0, 0);
        run_cycle(mk(C_RT, 0, 64'h300), 1'b0, "stl_unf");
        expect_regs("stl_unf", 64'h300, 0, 1);
        run_cycle(mk(C_LK, 64'h4, 0), 1'b0, "stl_push");
        expect_regs("stl_push", 64'h310, 1, 1);
        run_cycle(mk(C_RST | C_STL | C_LK, 64'h10, 0), 1'b0, "stl_rst_over");
        expect_regs("stl_rst_over", 64'h100, 0, 0);

        // ---------------- perf counter sequence ----------------
        check("perf_rst_taken", {32'd0, PerfTaken}, 64'd0);
        check("perf_rst_retired", {32'd0, PerfRetired}, 64'd0);
        run_cycle(mk(C_NOP, 0, 0), 1'b0, "perf0");
        run_cycle(mk(C_RB, 0, 64'h1000), 1'b0, "perf1");
        run_cycle(mk(C_STL, 0, 0), 1'b0, "perf2");
        run_cycle(mk(C_NOP, 0, 0), 1'b0, "perf3");
        run_cycle(mk(C_UB, 64'h8, 0), 1'b0, "perf4");
        run_cycle(mk(C_STL, 0, 0), 1'b0, "perf5");
        run_cycle(mk(C_NOP, 0, 0), 1'b0, "perf6");
        run_cycle(mk(C_BR | C_Z, 64'h2, 0), 1'b0, "perf7");
        run_cycle(mk(C_NOP, 0, 0), 1'b0, "perf8");
        run_cycle(mk(C_NOP, 0, 0), 1'b0, "perf9");
        check("perf_retired", {32'd0, PerfRetired}, PERF_EN ? 64'd8 : 64'd0);
        check("perf_taken",   {32'd0, PerfTaken},   PERF_EN ? 64'd3 : 64'd0);

        // ---------------- randomized against the model ----------------
        run_cycle(mk(C_RST, 0, 0), 1'b1, "rnd_rst");
        for (int n = 0; n < 600; n++) begin
            r.ctl[8] = ($urandom_range(63) == 0);
            r.ctl[7] = ($urandom_range(5) == 0);
            for (int b = 0; b < 7; b++) r.ctl[b] = ($urandom_range(4) == 0);
            if ($urandom_range(3) == 0) r.imm = {$urandom, $urandom};
            else r.imm = 64'($signed($urandom_range(64) - 32));
            r.rtgt = {$urandom, $urandom};
            run_cycle(r, 1'b1, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
